data_sync_capture: RTL and testbench
====================================

Name: data_sync_capture

Overview:
- Multi-bit clock-domain-crossing receiver, destination domain.
- Synchronizes a level enable from the source domain through a flop chain, detects its rising edge, and captures the quasi-static source bus on that edge.
- Presents the captured word through a valid/ready output buffer with overrun detection.
- Sits downstream of the single-bit synchronizer stage (built internally) and feeds destination-domain consumers.

Parameters:
- BUS_WIDTH, 8, width of data bus crossing domains (>=1).
- NUM_STAGES, 2, flops in enable synchronizer chain (>=2).
- CNT_WIDTH, 8, width of saturating capture counter (>=1).

Ports:
- CLK  input  1  destination-domain clock.
- RST  input  1  reset, asynchronous, active-low.
- UNSYNC_BUS  input  BUS_WIDTH  source-domain data; source holds stable while BUS_ENABLE high.
- BUS_ENABLE  input  1  source-domain level enable; rising edge = new word.
- OUT_READY  input  1  downstream accepts SYNC_BUS this cycle.
- OVERRUN_CLR  input  1  synchronous clear of OVERRUN.
- SYNC_BUS  output  BUS_WIDTH  captured word, registered.
- SYNC_VALID  output  1  SYNC_BUS holds unconsumed word.
- ENABLE_PULSE  output  1  one-cycle pulse, coincident with new SYNC_BUS.
- OVERRUN  output  1  sticky: unconsumed word was overwritten.
- CAPTURE_CNT  output  CNT_WIDTH  saturating count of captures.

Behaviour:
- Reset (RST=0, async): synchronizer chain, edge flop en_d, SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERRUN and CAPTURE_CNT all 0.
- Sync chain: stage0 <= BUS_ENABLE; stage[i] <= stage[i-1]; en_s = stage[NUM_STAGES-1].
- Edge detect: en_d <= en_s; rise = en_s & ~en_d, combinational and internal only.
- Capture: on an edge where rise=1:
  - SYNC_BUS <= UNSYNC_BUS.
  - ENABLE_PULSE <= 1.
  - SYNC_VALID <= 1.
  - CAPTURE_CNT increments unless all-ones.
- ENABLE_PULSE is 0 on every other edge; it is never high two consecutive cycles.
- Latency: BUS_ENABLE first sampled high at edge k -> SYNC_BUS/ENABLE_PULSE/SYNC_VALID change after edge k+NUM_STAGES.
- Retrigger rule: BUS_ENABLE held high produces exactly one capture. A new capture requires en_s to be seen low for >=1 cycle, so the source must hold it low >= NUM_STAGES+1 destination cycles.
- Handshake: at an edge with SYNC_VALID=1 and OUT_READY=1 and rise=0 -> SYNC_VALID <= 0; SYNC_BUS retains its value.
- OUT_READY while SYNC_VALID=0: no effect.
- Simultaneous capture and consume (SYNC_VALID=1, OUT_READY=1, rise=1): new word loaded, SYNC_VALID stays 1, OVERRUN unchanged.
- Overwrite (SYNC_VALID=1, OUT_READY=0, rise=1): new word replaces old (latest wins), SYNC_VALID stays 1, OVERRUN <= 1.
- OVERRUN: sticky. OVERRUN_CLR=1 clears it at the next edge; if set and clear coincide, set wins (OVERRUN=1).
- CAPTURE_CNT: saturates at 2^CNT_WIDTH-1; cleared only by reset.
- Reset mid-operation: any in-flight enable is discarded. If BUS_ENABLE is high across reset release, the chain refills and exactly one capture occurs NUM_STAGES edges after release, since en_d resets to 0.
- UNSYNC_BUS is never synchronized bitwise; it is sampled only on the rise edge.

Test Plan:
- Reset values (BUS_WIDTH=8, NUM_STAGES=2): hold RST=0 with BUS_ENABLE=1, UNSYNC_BUS=8'hFF -> all outputs 0. Release at edge 0 -> capture after edge 2: SYNC_BUS=8'hFF, ENABLE_PULSE high one cycle, CAPTURE_CNT=1.
- Basic transfer: UNSYNC_BUS=8'hA5, BUS_ENABLE 0->1 before edge k, OUT_READY=1 -> after edge k+2: SYNC_BUS=8'hA5, SYNC_VALID=1, ENABLE_PULSE=1. After edge k+3: SYNC_VALID=0, ENABLE_PULSE=0, SYNC_BUS still 8'hA5.
- Held enable: BUS_ENABLE high for 20 cycles -> exactly one ENABLE_PULSE, CAPTURE_CNT +1.
- Overrun: OUT_READY=0; send 8'h11, then 8'h22 (enable low 4 cycles between) -> SYNC_BUS=8'h22, SYNC_VALID=1, OVERRUN=1. Pulse OVERRUN_CLR -> OVERRUN=0. Assert OVERRUN_CLR on the edge of a third overwriting capture -> OVERRUN=1.
- Simultaneous consume+capture: SYNC_VALID=1 (8'h33), OUT_READY=1 on the capture edge of 8'h44 -> SYNC_BUS=8'h44, SYNC_VALID=1, OVERRUN=0.
- Saturation (CNT_WIDTH=2): perform 5 transfers -> CAPTURE_CNT=3. Async RST pulse mid-chain (enable in stage0 only) -> no capture after reset if BUS_ENABLE is low at release.

Source files
------------

// File: rtl/data_sync_capture.sv
// Destination-domain CDC receiver: synchronizes a level enable, captures the
// quasi-static source bus on its rising edge and holds it in a valid/ready buffer.
module data_sync_capture #(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    input  logic                 OUT_READY,
    input  logic                 OVERRUN_CLR,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 SYNC_VALID,
    output logic                 ENABLE_PULSE,
    output logic                 OVERRUN,
    output logic [CNT_WIDTH-1:0] CAPTURE_CNT
);

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  en_d_q;
    logic                  en_s;
    logic                  rise;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  valid_q, valid_d;
    logic                  pulse_q, pulse_d;
    logic                  ovr_q, ovr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
        en_s    = sync_q[NUM_STAGES-1];
        rise    = en_s & ~en_d_q;

        bus_d   = bus_q;
        valid_d = valid_q;
        pulse_d = rise;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;

        // A capture always leaves the buffer valid, even if it was consumed this cycle.
        if (rise) begin
            bus_d   = UNSYNC_BUS;
            valid_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end

        // Set takes priority over clear so an overwrite is never lost.
        if (OVERRUN_CLR) begin
            ovr_d = 1'b0;
        end
        if (rise && valid_q && !OUT_READY) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= '0;
            en_d_q  <= 1'b0;
            bus_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            en_d_q  <= en_s;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign SYNC_BUS     = bus_q;
    assign SYNC_VALID   = valid_q;
    assign ENABLE_PULSE = pulse_q;
    assign OVERRUN      = ovr_q;
    assign CAPTURE_CNT  = cnt_q;

endmodule

// File: tb/tb_data_sync_capture.sv
// Bench for data_sync_capture: directed scenarios then random traffic, checked
// against a history-based reference model on two instances (8-bit and 2-bit counters).
module tb_data_sync_capture;

    localparam int unsigned BW = 8;
    localparam int unsigned NS = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic [BW-1:0] UNSYNC_BUS;
    logic          BUS_ENABLE;
    logic          OUT_READY;
    logic          OVERRUN_CLR;

    logic [BW-1:0] a_bus,  b_bus;
    logic          a_val,  b_val;
    logic          a_pls,  b_pls;
    logic          a_ovr,  b_ovr;
    logic [7:0]    a_cnt;
    logic [1:0]    b_cnt;

    data_sync_capture #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .CNT_WIDTH(8)) dut_a (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_ENABLE(BUS_ENABLE),
        .OUT_READY(OUT_READY), .OVERRUN_CLR(OVERRUN_CLR),
        .SYNC_BUS(a_bus), .SYNC_VALID(a_val), .ENABLE_PULSE(a_pls),
        .OVERRUN(a_ovr), .CAPTURE_CNT(a_cnt)
    );

    data_sync_capture #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .CNT_WIDTH(2)) dut_b (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_ENABLE(BUS_ENABLE),
        .OUT_READY(OUT_READY), .OVERRUN_CLR(OVERRUN_CLR),
        .SYNC_BUS(b_bus), .SYNC_VALID(b_val), .ENABLE_PULSE(b_pls),
        .OVERRUN(b_ovr), .CAPTURE_CNT(b_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: enable samples taken since reset release, one per edge.
    bit            hist[$];
    logic [BW-1:0] m_bus;
    logic          m_val, m_pls, m_ovr;
    int            m_cnt_a, m_cnt_b;

    function automatic bit sample_at(int idx);
        if (idx < 0 || idx >= hist.size()) return 1'b0;
        return hist[idx];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_bus = '0; m_val = 0; m_pls = 0; m_ovr = 0;
        m_cnt_a = 0; m_cnt_b = 0;
    endtask

    // Capture at edge t iff the enable was high NS edges earlier and low the edge before that.
    task automatic model_edge();
        int t;
        bit r;
        if (!RST) begin
            model_reset();
            return;
        end
        t = hist.size();
        r = sample_at(t - int'(NS)) && !sample_at(t - int'(NS) - 1);
        if (r && m_val && !OUT_READY) m_ovr = 1;
        else if (OVERRUN_CLR)         m_ovr = 0;
        if (r) begin
            m_bus   = UNSYNC_BUS;
            m_val   = 1;
            m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
            m_cnt_b = (m_cnt_b < 3)   ? m_cnt_b + 1 : 3;
        end else if (m_val && OUT_READY) begin
            m_val = 0;
        end
        m_pls = r;
        hist.push_back(BUS_ENABLE);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a_bus"}, 32'(a_bus), 32'(m_bus));
        chk({tag, ".a_val"}, 32'(a_val), 32'(m_val));
        chk({tag, ".a_pls"}, 32'(a_pls), 32'(m_pls));
        chk({tag, ".a_ovr"}, 32'(a_ovr), 32'(m_ovr));
        chk({tag, ".a_cnt"}, 32'(a_cnt), 32'(m_cnt_a));
        chk({tag, ".b_bus"}, 32'(b_bus), 32'(m_bus));
        chk({tag, ".b_val"}, 32'(b_val), 32'(m_val));
        chk({tag, ".b_pls"}, 32'(b_pls), 32'(m_pls));
        chk({tag, ".b_ovr"}, 32'(b_ovr), 32'(m_ovr));
        chk({tag, ".b_cnt"}, 32'(b_cnt), 32'(m_cnt_b));
    endtask

    task automatic tick(input logic en, input logic [BW-1:0] bus, input logic rdy,
                        input logic clr, input string tag);
        BUS_ENABLE  = en;
        UNSYNC_BUS  = bus;
        OUT_READY   = rdy;
        OVERRUN_CLR = clr;
        @(posedge CLK);
        model_edge();
        #1 check_all(tag);
    endtask

    task automatic idle(input int n, input logic rdy, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, rdy, 1'b0, tag);
    endtask

    initial begin
        logic          ren;
        logic [BW-1:0] rbus;
        model_reset();

        // Reset with enable and data already high: everything must read zero.
        RST = 1'b0; BUS_ENABLE = 1'b1; UNSYNC_BUS = 8'hFF; OUT_READY = 1'b0; OVERRUN_CLR = 1'b0;
        #1 check_all("rst_hold");
        tick(1'b1, 8'hFF, 1'b0, 1'b0, "rst_hold");
        tick(1'b1, 8'hFF, 1'b0, 1'b0, "rst_hold");
        RST = 1'b1;
        tick(1'b1, 8'hFF, 1'b0, 1'b0, "rel_e0");
        chk("rel_e0_pls", 32'(a_pls), 32'd0);
        tick(1'b1, 8'hFF, 1'b0, 1'b0, "rel_e1");
        tick(1'b1, 8'hFF, 1'b0, 1'b0, "rel_e2");
        chk("rel_cap_bus", 32'(a_bus), 32'hFF);
        chk("rel_cap_pls", 32'(a_pls), 32'd1);
        chk("rel_cap_cnt", 32'(a_cnt), 32'd1);
        tick(1'b1, 8'hFF, 1'b0, 1'b0, "rel_e3");
        chk("rel_pls_drop", 32'(a_pls), 32'd0);

        // Basic transfer with downstream ready, then enable held 20 cycles.
        idle(4, 1'b1, "gap1");
        tick(1'b1, 8'hA5, 1'b1, 1'b0, "xfer_k");
        tick(1'b1, 8'hA5, 1'b1, 1'b0, "xfer_k1");
        tick(1'b1, 8'hA5, 1'b1, 1'b0, "xfer_k2");
        chk("xfer_bus", 32'(a_bus), 32'hA5);
        chk("xfer_val", 32'(a_val), 32'd1);
        chk("xfer_pls", 32'(a_pls), 32'd1);
        tick(1'b1, 8'hA5, 1'b1, 1'b0, "xfer_k3");
        chk("xfer_consumed", 32'(a_val), 32'd0);
        chk("xfer_keep_bus", 32'(a_bus), 32'hA5);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'hA5, 1'b1, 1'b0, "held");
        chk("held_one_cap", 32'(a_cnt), 32'd2);

        // Overrun: two unconsumed captures, clear, then set/clear collision.
        idle(4, 1'b0, "gap2");
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h11, 1'b0, 1'b0, "w11");
        idle(4, 1'b0, "gap3");
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h22, 1'b0, 1'b0, "w22");
        chk("ovr_bus", 32'(a_bus), 32'h22);
        chk("ovr_val", 32'(a_val), 32'd1);
        chk("ovr_set", 32'(a_ovr), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clr");
        chk("ovr_cleared", 32'(a_ovr), 32'd0);
        idle(3, 1'b0, "gap4");
        tick(1'b1, 8'h33, 1'b0, 1'b0, "w33");
        tick(1'b1, 8'h33, 1'b0, 1'b0, "w33");
        tick(1'b1, 8'h33, 1'b0, 1'b1, "w33_clr");
        chk("ovr_set_wins", 32'(a_ovr), 32'd1);

        // Consume and capture on the same edge: no overrun.
        tick(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clr2");
        idle(3, 1'b0, "gap5");
        tick(1'b1, 8'h44, 1'b0, 1'b0, "w44");
        tick(1'b1, 8'h44, 1'b0, 1'b0, "w44");
        tick(1'b1, 8'h44, 1'b1, 1'b0, "w44_rdy");
        chk("sim_bus", 32'(a_bus), 32'h44);
        chk("sim_val", 32'(a_val), 32'd1);
        chk("sim_ovr", 32'(a_ovr), 32'd0);
        chk("sat_cnt_b", 32'(b_cnt), 32'd3);
        chk("cnt_a_six", 32'(a_cnt), 32'd6);

        // Reset while the enable is only in the first stage: it must be discarded.
        idle(4, 1'b1, "gap6");
        tick(1'b1, 8'h55, 1'b1, 1'b0, "mid_e0");
        RST = 1'b0;
        model_reset();
        #1 check_all("mid_rst");
        tick(1'b0, 8'h55, 1'b1, 1'b0, "mid_rst");
        RST = 1'b1;
        idle(6, 1'b1, "mid_rel");
        chk("mid_no_cap", 32'(a_cnt), 32'd0);

        // Random traffic: bus only changes while the enable is low.
        ren = 1'b0; rbus = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) ren = ~ren;
            if (!ren) rbus = BW'($urandom);
            tick(ren, rbus, 1'($urandom_range(2) != 0), 1'($urandom_range(7) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
